gt_drp_arbiter: RTL and testbench

- Shares one GT DRP port between NREQ requesters, for example the PCIe-side DRP bridge, the rate-change sequencer and the eye-scan engine.
- Arbitration is round-robin.
- Supports read, write and masked read-modify-write (RMW). A hung DRP is recovered by a per-access timeout.
- Sits in the drp_clock domain, directly in front of the transceiver DRP pins. Any clock-crossing is done by the requesters.

---
 rtl/gt_drp_pkg.sv | 30 +++
 rtl/gt_drp_rr_arb.sv | 31 +++
 rtl/gt_drp_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_gt_drp_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_drp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gt_drp_pkg : shared constants for the GT DRP arbiter                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gt_drp_pkg;

    localparam int DRP_AW = 9;
    localparam int DRP_DW = 16;

    localparam logic [DRP_DW-1:0] MASK_ALL = 16'hFFFF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Masked bits come from the new data, the rest from the value read back.
    function automatic logic [DRP_DW-1:0] rmw_merge(
        input logic [DRP_DW-1:0] data,
        input logic [DRP_DW-1:0] mask,
        input logic [DRP_DW-1:0] old
    );
        return (data & mask) | (old & ~mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gt_drp_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gt_drp_rr_arb : combinational round-robin grant, search starts at ptr    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gt_drp_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    logic [NREQ-1:0] w_hi_mask;
    logic [NREQ-1:0] w_masked;
    logic [NREQ-1:0] w_pick;

    for (genvar i = 0; i < NREQ; i++) begin : g_mask
        assign w_hi_mask[i] = (PTR_W'(i) >= ptr);
    end

    // Requests at or above the pointer win; otherwise wrap to the lowest one.
    assign w_masked = req & w_hi_mask;
    assign w_pick   = (|w_masked) ? w_masked : req;
    assign grant    = w_pick & (-w_pick);
    assign valid    = |req;

endmodule
`default_nettype wire

// File: rtl/gt_drp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gt_drp_arbiter : round-robin sharing of one GT DRP port (rd/wr/RMW)      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gt_drp_arbiter
    import gt_drp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*DRP_AW-1:0]   req_address,
    input  logic [NREQ*DRP_DW-1:0]   req_data,
    input  logic [NREQ*DRP_DW-1:0]   req_mask,
    output logic [NREQ-1:0]          ack,
    output logic [DRP_DW-1:0]        rdata,
    output logic                     error,
    output logic                     busy,
    output logic [DRP_AW-1:0]        drp_address,
    output logic                     drp_en,
    output logic                     drp_we,
    output logic [DRP_DW-1:0]        drp_di,
    input  logic [DRP_DW-1:0]        drp_do,
    input  logic                     drp_ready
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [2:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_grant;
    logic              r_rmw;
    logic [DRP_DW-1:0] r_data;
    logic [DRP_DW-1:0] r_mask;
    logic [CNT_W-1:0]  r_cnt;

    logic [NREQ-1:0]   w_grant;
    logic              w_valid;
    logic [PTR_W-1:0]  w_sel_idx;
    logic [PTR_W-1:0]  w_next_ptr;
    logic              w_sel_we;
    logic [DRP_AW-1:0] w_sel_addr;
    logic [DRP_DW-1:0] w_sel_data;
    logic [DRP_DW-1:0] w_sel_mask;
    logic              w_timeout;

    gt_drp_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .valid (w_valid)
    );

    always_comb begin
        w_sel_idx  = '0;
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_idx  = PTR_W'(i);
                w_sel_we   = req_we[i];
                w_sel_addr = req_address[i*DRP_AW +: DRP_AW];
                w_sel_data = req_data[i*DRP_DW +: DRP_DW];
                w_sel_mask = req_mask[i*DRP_DW +: DRP_DW];
            end
        end
    end

    assign w_next_ptr = (w_sel_idx == PTR_W'(NREQ - 1)) ? '0 : w_sel_idx + PTR_W'(1);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_rmw       <= 1'b0;
            r_data      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            ack         <= '0;
            rdata       <= '0;
            error       <= 1'b0;
            busy        <= 1'b0;
            drp_address <= '0;
            drp_en      <= 1'b0;
            drp_we      <= 1'b0;
            drp_di      <= '0;
        end else begin
            ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_grant;
                        r_ptr       <= w_next_ptr;
                        r_rmw       <= w_sel_we && (w_sel_mask != MASK_ALL);
                        r_data      <= w_sel_data;
                        r_mask      <= w_sel_mask;
                        r_cnt       <= '0;
                        drp_address <= w_sel_addr;
                        rdata       <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        drp_en      <= 1'b1;
                        if (w_sel_we && (w_sel_mask == MASK_ALL)) begin
                            drp_we  <= 1'b1;
                            drp_di  <= w_sel_data;
                            r_state <= ST_WR_ISSUE;
                        end else begin
                            drp_we  <= 1'b0;
                            r_state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    drp_en  <= 1'b0;
                    drp_we  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (drp_ready) begin
                        rdata <= drp_do;
                        if (r_rmw) begin
                            drp_di  <= rmw_merge(r_data, r_mask, drp_do);
                            drp_en  <= 1'b1;
                            drp_we  <= 1'b1;
                            r_state <= ST_WR_ISSUE;
                        end else begin
                            ack     <= r_grant;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        // A timed-out RMW read never issues its write.
                        rdata   <= '0;
                        error   <= 1'b1;
                        ack     <= r_grant;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WR_ISSUE: begin
                    drp_en  <= 1'b0;
                    drp_we  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (drp_ready) begin
                        ack     <= r_grant;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        rdata   <= '0;
                        error   <= 1'b1;
                        ack     <= r_grant;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    error   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    drp_en  <= 1'b0;
                    drp_we  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gt_drp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gt_drp_arbiter : directed self-checking bench for gt_drp_arbiter      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gt_drp_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*9-1:0] req_address;
    logic [NREQ*16-1:0] req_data;
    logic [NREQ*16-1:0] req_mask;
    logic [NREQ-1:0]   ack;
    logic [15:0]       rdata;
    logic              error;
    logic              busy;
    logic [8:0]        drp_address;
    logic              drp_en;
    logic              drp_we;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_ready;

    int checks = 0;
    int errors = 0;
    int n_en   = 0;
    int n_wr   = 0;
    int n_ack  = 0;

    gt_drp_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_address (req_address),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .ack         (ack),
        .rdata       (rdata),
        .error       (error),
        .busy        (busy),
        .drp_address (drp_address),
        .drp_en      (drp_en),
        .drp_we      (drp_we),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_ready   (drp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Event counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (drp_en) begin
            n_en++;
            if (drp_we) n_wr++;
        end
        if (|ack) n_ack++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] addr,
                           input logic [15:0] data, input logic [15:0] mask);
        req_we[i]              = we;
        req_address[i*9 +: 9]  = addr;
        req_data[i*16 +: 16]   = data;
        req_mask[i*16 +: 16]   = mask;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        while (ack == '0 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_en(input int max, output int n);
        n = 0;
        while (!drp_en && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_en, s_wr, s_ack, n, e;

        reset       = 1'b1;
        req_valid   = '0;
        req_we      = '0;
        req_address = '0;
        req_data    = '0;
        req_mask    = '0;
        drp_do      = '0;
        drp_ready   = 1'b0;
        repeat (3) tick();

        chk("reset_busy", busy, 0);
        chk("reset_drp_en", drp_en, 0);
        chk("reset_ack", ack, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_drp_address", drp_address, 0);
        chk("reset_error", error, 0);
        reset = 1'b0;
        tick();

        // Single read, requester 0, ready three cycles after drp_en.
        set_req(0, 1'b0, 9'h011, 16'h0000, 16'h0000);
        req_valid = 4'b0001;
        s_en = n_en; s_wr = n_wr;
        tick();
        chk("rd_en", drp_en, 1);
        chk("rd_we", drp_we, 0);
        chk("rd_addr", drp_address, 32'h011);
        chk("rd_busy", busy, 1);
        tick();
        chk("rd_en_pulse", drp_en, 0);
        tick();
        tick();
        drp_ready = 1'b1; drp_do = 16'hBEEF;
        tick();
        chk("rd_ack", ack, 4'b0001);
        chk("rd_rdata", rdata, 16'hBEEF);
        chk("rd_error", error, 0);
        drp_ready = 1'b0; req_valid = '0;
        tick();
        chk("rd_ack_pulse", ack, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_en_count", n_en - s_en, 1);
        chk("rd_wr_count", n_wr - s_wr, 0);

        // Plain write, requester 2.
        set_req(2, 1'b1, 9'h022, 16'h1234, 16'hFFFF);
        req_valid = 4'b0100;
        s_en = n_en; s_wr = n_wr;
        tick();
        chk("wr_en", drp_en, 1);
        chk("wr_we", drp_we, 1);
        chk("wr_di", drp_di, 16'h1234);
        chk("wr_addr", drp_address, 32'h022);
        tick();
        chk("wr_we_off", drp_we, 0);
        drp_ready = 1'b1; drp_do = 16'hDEAD;
        tick();
        chk("wr_ack", ack, 4'b0100);
        chk("wr_rdata", rdata, 0);
        chk("wr_error", error, 0);
        drp_ready = 1'b0; req_valid = '0;
        tick();
        chk("wr_en_count", n_en - s_en, 1);
        chk("wr_wr_count", n_wr - s_wr, 1);

        // RMW, requester 1: 0x00A5 under 0x00FF onto 0x5A3C -> 0x5AA5.
        set_req(1, 1'b1, 9'h033, 16'h00A5, 16'h00FF);
        req_valid = 4'b0010;
        s_en = n_en; s_wr = n_wr;
        tick();
        chk("rmw_rd_en", drp_en, 1);
        chk("rmw_rd_we", drp_we, 0);
        chk("rmw_addr", drp_address, 32'h033);
        tick();
        drp_ready = 1'b1; drp_do = 16'h5A3C;
        tick();
        chk("rmw_wr_en", drp_en, 1);
        chk("rmw_wr_we", drp_we, 1);
        chk("rmw_wr_di", drp_di, 16'h5AA5);
        drp_ready = 1'b0; drp_do = 16'h0000;
        tick();
        drp_ready = 1'b1;
        tick();
        chk("rmw_ack", ack, 4'b0010);
        chk("rmw_rdata", rdata, 16'h5A3C);
        chk("rmw_error", error, 0);
        drp_ready = 1'b0; req_valid = '0;
        tick();
        chk("rmw_en_count", n_en - s_en, 2);
        chk("rmw_wr_count", n_wr - s_wr, 1);

        // Read timeout on requester 3, then a late drp_ready.
        set_req(3, 1'b0, 9'h044, 16'h0000, 16'h0000);
        req_valid = 4'b1000;
        s_ack = n_ack;
        tick();
        chk("to_rd_en", drp_en, 1);
        tick();
        wait_ack(100, n);
        chk("to_latency", n, TIMEOUT);
        chk("to_ack", ack, 4'b1000);
        chk("to_error", error, 1);
        chk("to_rdata", rdata, 0);
        req_valid = '0;
        repeat (10) tick();
        drp_ready = 1'b1;
        tick();
        drp_ready = 1'b0;
        repeat (3) tick();
        chk("to_late_ready_no_ack", n_ack - s_ack, 1);
        chk("to_idle_busy", busy, 0);

        // RMW whose read times out must not issue the write.
        set_req(0, 1'b1, 9'h055, 16'h1111, 16'h0F0F);
        req_valid = 4'b0001;
        s_en = n_en; s_wr = n_wr;
        tick();
        chk("rmwto_rd_en", drp_en, 1);
        wait_ack(100, n);
        chk("rmwto_latency", n, TIMEOUT + 1);
        chk("rmwto_ack", ack, 4'b0001);
        chk("rmwto_error", error, 1);
        req_valid = '0;
        repeat (3) tick();
        chk("rmwto_en_count", n_en - s_en, 1);
        chk("rmwto_wr_count", n_wr - s_wr, 0);

        // Reset in RD_WAIT with stray drp_ready during and after reset.
        set_req(2, 1'b0, 9'h066, 16'h0000, 16'h0000);
        req_valid = 4'b0100;
        s_ack = n_ack;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_addr", drp_address, 0);
        chk("rst_async_en", drp_en, 0);
        req_valid = '0;
        drp_ready = 1'b1; drp_do = 16'h7777;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        drp_ready = 1'b0;
        tick();
        chk("rst_no_ack", n_ack - s_ack, 0);
        chk("rst_idle_busy", busy, 0);
        chk("rst_rdata", rdata, 0);

        // All four requesters held: grants 0,1,2,3,0 starting from pointer 0.
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b0, 9'(32'h100 + i), 16'h0000, 16'h0000);
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            e = t % NREQ;
            wait_en(20, n);
            chk($sformatf("rr%0d_en_seen", t), drp_en, 1);
            chk($sformatf("rr%0d_addr", t), drp_address, 32'h100 + e);
            tick();
            chk($sformatf("rr%0d_busy", t), busy, 1);
            tick();
            drp_ready = 1'b1; drp_do = 16'(32'hA000 + t);
            tick();
            chk($sformatf("rr%0d_ack", t), ack, 32'(1) << e);
            chk($sformatf("rr%0d_rdata", t), rdata, 32'hA000 + t);
            drp_ready = 1'b0;
            if (t == 4) req_valid = '0;
        end
        repeat (3) tick();
        chk("rr_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
